phy_tx_lane_serializer: RTL and testbench
=========================================

// Module: phy_tx_lane_serializer
// PURPOSE
//  Per-lane parallel-to-serial stage fed by one byte lane of PHY_TX (data_out_N/valid_outN).
//  Converts each 8-bit symbol to a 1-bit stream, MSB first, one bit per clk_8f cycle.
//  Transmits COM symbols for lane synchronisation before payload is accepted.
//  Fills empty symbol slots with IDL. One instance per lane.
// PARAMETERS
//  WIDTH       8      symbol width in bits (bit counter is $clog2(WIDTH) wide)
//  COM         8'hBC  comma/sync symbol
//  IDL         8'h7C  idle filler symbol
//  SYNC_COUNT  4      number of COM symbols sent before ACTIVE may be entered
// PORTS
//  clk_8f      in   1      bit-rate clock; single clock domain; all logic on its rising edge
//  reset       in   1      asynchronous, active-high; clears all state immediately
//  data_in     in   WIDTH  payload byte from the PHY_TX lane
//  valid_in    in   1      data_in holds a valid byte
//  active_in   in   1      upstream permits payload transmission
//  ready_out   out  1      symbol slot open this cycle; data_in is consumed at this edge if valid_in
//  serial_out  out  1      serial bit stream, MSB first
//  sym_start   out  1      high while serial_out carries bit 7 of a symbol
//  active_out  out  1      high while the FSM is in ACTIVE
// BEHAVIOUR
//  Reset values: shreg=0, bit_cnt=0, com_cnt=0, state=SYNC.
//   Outputs during reset: serial_out=0, sym_start=0, active_out=0, ready_out=0.
//  Reset asserted mid-symbol: current symbol is abandoned and all state clears at once.
//  Symbol timing:
//   - A load edge is any rising edge where bit_cnt==0.
//   - At a load edge: shreg <= next symbol and bit_cnt <= 1.
//   - At every other edge: shreg <= shreg<<1 and bit_cnt <= bit_cnt+1, wrapping from WIDTH-1 to 0.
//   - serial_out = shreg[WIDTH-1], driven directly from the register.
//   - sym_start = (bit_cnt==1).
//   - Each symbol therefore occupies exactly WIDTH cycles, back to back, with no gaps.
//  Latency: a byte sampled at load edge T drives its MSB on serial_out for cycle T..T+1.
//   Its LSB appears at cycle T+7.
//  Handshake: ready_out = (state==ACTIVE) && (bit_cnt==0), combinational from registers.
//   - A transfer occurs when valid_in && ready_out at an edge.
//   - valid_in while ready_out=0 is ignored. The block never stores a byte; upstream must hold it.
//  Next-symbol selection at a load edge:
//   - state SYNC: COM.
//   - state ACTIVE: data_in if valid_in, otherwise IDL.
//  FSM, evaluated only at load edges:
//   SYNC:
//    - Sends COM; com_cnt increments and saturates at SYNC_COUNT.
//    - Moves to ACTIVE when com_cnt==SYNC_COUNT && active_in. The first ACTIVE slot is the following load edge.
//    - If active_in is low, stays in SYNC and keeps sending COM.
//   ACTIVE:
//    - Moves to SYNC when active_in==0; com_cnt <= 0.
//    - The symbol loaded at that edge is COM, so a full SYNC_COUNT commas are required again.
//  active_in toggling between load edges has no effect; only its value at load edges is used.
//  Byte 8'hBC sent as payload in ACTIVE is transmitted verbatim. No escaping or special handling.
// STRUCTURE
//  Shared include phy_defs.vh holds:
//   - `COM_SYM and `IDL_SYM
//   - state encodings: SYNC=1'b0, ACTIVE=1'b1
//  PHY_RX reuses the same include for comma detection.
//  Single flat module; no sub-module is required.
//  Registers: shreg[WIDTH-1:0], bit_cnt, com_cnt[$clog2(SYNC_COUNT+1)-1:0], state.
// TESTING
//  1. Reset release, active_in=0 for 64 cycles:
//     serial_out repeats 1011_1100 every 8 cycles. ready_out never asserts; active_out=0.
//  2. active_in=1 from reset:
//     exactly 4 COM symbols are sent, then active_out=1. The first ready_out occurs at cycle 32 after reset release.
//  3. In ACTIVE, send bytes 8'hA5 then 8'h3C with valid_in held:
//     serial_out = 10100101 00111100, with sym_start high on each leading bit.
//  4. In ACTIVE, valid_in=0 for one slot between two bytes:
//     the slot carries IDL 0111_1100, and the following byte is unshifted.
//  5. Drop active_in mid-symbol in ACTIVE:
//     the current byte completes, then 4 COM symbols are sent before ready_out reasserts.
//  6. Assert reset at bit 3 of 8'hFF:
//     serial_out=0 immediately. After release the stream restarts with COM at bit 7.

Source files
------------

// File: rtl/phy_tx_lane_serializer_pkg.sv
// -----------------------------------------------------------------------------
// phy_tx_lane_serializer_pkg
//   Shared definitions for the per-lane transmit serializer. The PHY_RX comma
//   detector imports the same symbol values, so keep them here and not in the
//   serializer itself.
//   Contents:
//     WIDTH_DEF       default symbol width in bits
//     SYNC_COUNT_DEF  default number of commas sent before payload is allowed
//     COM_SYM         comma / lane-sync symbol
//     IDL_SYM         idle filler symbol
//     lane_state_e    lane FSM states (SYNC = 0, ACTIVE = 1)
// -----------------------------------------------------------------------------
package phy_tx_lane_serializer_pkg;

  localparam int WIDTH_DEF      = 8;
  localparam int SYNC_COUNT_DEF = 4;

  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam logic [7:0] IDL_SYM = 8'h7C;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } lane_state_e;

endpackage : phy_tx_lane_serializer_pkg

// File: rtl/phy_tx_lane_serializer_if.sv
// -----------------------------------------------------------------------------
// phy_tx_lane_serializer_if
//   Byte-lane handshake between one PHY_TX byte lane and its serializer.
//   Signals:
//     data_in    payload byte from the PHY_TX lane
//     valid_in   data_in holds a valid byte
//     active_in  upstream permits payload transmission
//     ready_out  symbol slot open this cycle; data_in is consumed at the next
//                rising edge when valid_in is also high
//   Modports:
//     master  upstream PHY_TX lane (drives data/valid/active, sees ready)
//     slave   serializer
// -----------------------------------------------------------------------------
interface phy_tx_lane_serializer_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             active_in;
  logic             ready_out;

  modport master (
    output data_in,
    output valid_in,
    output active_in,
    input  ready_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    input  active_in,
    output ready_out
  );

endinterface : phy_tx_lane_serializer_if

// File: rtl/phy_tx_lane_serializer_shifter.sv
// -----------------------------------------------------------------------------
// phy_tx_lane_serializer_shifter
//   Symbol slot timer and MSB-first shift register. Every WIDTH cycles it
//   opens a load slot (bit_cnt == 0) and captures next_sym; in between it
//   shifts left by one. Symbols follow each other with no gap.
//   WIDTH must be at least 2.
//   Ports:
//     clk_8f      in   bit-rate clock
//     reset       in   asynchronous, active-high
//     next_sym    in   symbol captured at the next load edge
//     load        out  next rising edge is a load edge (bit_cnt == 0)
//     serial_out  out  shreg MSB, straight from the register
//     sym_start   out  serial_out is carrying the leading bit of a symbol
// -----------------------------------------------------------------------------
module phy_tx_lane_serializer_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_8f,
  input  logic             reset,
  input  logic [WIDTH-1:0] next_sym,
  output logic             load,
  output logic             serial_out,
  output logic             sym_start
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;

  assign load       = (bit_cnt == '0);
  assign serial_out = shreg[WIDTH-1];
  // bit_cnt is already 1 while the leading bit of a freshly loaded symbol is
  // on the line, because the load edge itself advances the counter.
  assign sym_start  = (bit_cnt == CNT_W'(1));

  // NOTE: state updates use non-blocking assignments so every register in the
  // block sees the pre-edge value of every other register, whatever the
  // statement order.
  // NOTE: shreg is a datapath register but it is reset anyway: serial_out is
  // taken straight from its MSB and must read 0 the moment reset asserts.
  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= next_sym;
      bit_cnt <= CNT_W'(1);
    end else begin
      shreg   <= shreg << 1;
      bit_cnt <= (bit_cnt == CNT_W'(WIDTH - 1)) ? '0 : bit_cnt + CNT_W'(1);
    end
  end

endmodule : phy_tx_lane_serializer_shifter

// File: rtl/phy_tx_lane_serializer.sv
// -----------------------------------------------------------------------------
// phy_tx_lane_serializer
//   Per-lane parallel-to-serial stage behind one byte lane of PHY_TX.
//   After reset the lane sends SYNC_COUNT comma symbols; once those are out
//   and upstream raises active_in, payload slots open. Each open slot carries
//   the offered byte, or IDL when nothing is offered. Dropping active_in at a
//   slot sends the lane back to comma sync. Payload bytes equal to COM are sent
//   unchanged.
//   Ports:
//     clk_8f      in   bit-rate clock, one serial bit per cycle
//     reset       in   asynchronous, active-high; abandons any symbol in flight
//     lane        slave modport of phy_tx_lane_serializer_if
//                      (data_in, valid_in, active_in -> ready_out)
//     serial_out  out  serial bit stream, MSB first
//     sym_start   out  high while serial_out carries the symbol MSB
//     active_out  out  lane FSM is in ACTIVE
// -----------------------------------------------------------------------------
module phy_tx_lane_serializer
  import phy_tx_lane_serializer_pkg::*;
#(
  parameter int               WIDTH      = WIDTH_DEF,
  parameter logic [WIDTH-1:0] COM        = WIDTH'(COM_SYM),
  parameter logic [WIDTH-1:0] IDL        = WIDTH'(IDL_SYM),
  parameter int               SYNC_COUNT = SYNC_COUNT_DEF
) (
  input  logic                     clk_8f,
  input  logic                     reset,
  phy_tx_lane_serializer_if.slave  lane,
  output logic                     serial_out,
  output logic                     sym_start,
  output logic                     active_out
);

  localparam int CW = $clog2(SYNC_COUNT + 1);

  lane_state_e      state_q, state_d;
  logic [CW-1:0]    com_cnt_q, com_cnt_d;
  logic             load;
  logic [WIDTH-1:0] next_sym;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CW'(SYNC_COUNT)) ? v : v + CW'(1);
  endfunction

  // Slot timing and shifting.
  phy_tx_lane_serializer_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk_8f     (clk_8f),
    .reset      (reset),
    .next_sym   (next_sym),
    .load       (load),
    .serial_out (serial_out),
    .sym_start  (sym_start)
  );

  // Both outputs come from registers only, so upstream sees a glitch-free
  // ready for the whole cycle before the load edge.
  assign lane.ready_out = (state_q == ACTIVE) && load;
  assign active_out     = (state_q == ACTIVE);

  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      state_q   <= SYNC;
      com_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      com_cnt_q <= com_cnt_d;
    end
  end

  // The FSM only moves at load edges; between them active_in is ignored.
  // The comma count includes the comma loaded at the current edge, so the
  // edge that loads the last of SYNC_COUNT commas is also the edge that may
  // enter ACTIVE, and the very next slot is already a payload slot.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    com_cnt_d = com_cnt_q;
    next_sym  = COM;

    if (load) begin
      unique case (state_q)
        SYNC: begin
          next_sym  = COM;
          com_cnt_d = sat_inc(com_cnt_q);
          if ((com_cnt_d == CW'(SYNC_COUNT)) && lane.active_in) begin
            state_d = ACTIVE;
          end
        end

        ACTIVE: begin
          if (!lane.active_in) begin
            // Leaving ACTIVE restarts the sync sequence from zero; the comma
            // loaded here is the first of the new sequence.
            state_d   = SYNC;
            next_sym  = COM;
            com_cnt_d = sat_inc('0);
          end else begin
            next_sym = lane.valid_in ? lane.data_in : IDL;
          end
        end

        default: begin
          state_d   = SYNC;
          com_cnt_d = '0;
        end
      endcase
    end
  end

endmodule : phy_tx_lane_serializer

// File: tb/tb_phy_tx_lane_serializer.sv
// -----------------------------------------------------------------------------
// tb_phy_tx_lane_serializer
//   Scoreboard bench: each symbol the lane should transmit is pushed as eight
//   expected (bit, sym_start) pairs when the stimulus that causes it is
//   applied; a negedge monitor pops one pair per cycle and compares it with
//   serial_out / sym_start. Handshake and state outputs are compared inline by
//   the scenario tasks. Inputs change on the falling edge; outputs are read on
//   the falling edge.
// -----------------------------------------------------------------------------
module tb_phy_tx_lane_serializer;

  localparam logic [7:0] COM_B = 8'hBC;
  localparam logic [7:0] IDL_B = 8'h7C;

  logic clk_8f = 1'b0;
  logic reset  = 1'b1;
  logic serial_out;
  logic sym_start;
  logic active_out;

  phy_tx_lane_serializer_if #(.WIDTH(8)) lane ();

  phy_tx_lane_serializer dut (
    .clk_8f     (clk_8f),
    .reset      (reset),
    .lane       (lane),
    .serial_out (serial_out),
    .sym_start  (sym_start),
    .active_out (active_out)
  );

  always #5 clk_8f = ~clk_8f;

  typedef struct {
    logic b;
    logic s;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  // Serial stream monitor: one expected bit per cycle while enabled.
  always @(negedge clk_8f) begin
    if (mon_en && !reset) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL stream_underflow: serial_out=%0b with no expected bit queued at %0t",
                 serial_out, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (serial_out !== e.b || sym_start !== e.s) begin
          n_fail++;
          $display("FAIL stream_bit: serial_out=%0b sym_start=%0b, expected %0b/%0b at %0t",
                   serial_out, sym_start, e.b, e.s, $time);
        end
      end
    end
  end

  task automatic push_sym(input logic [7:0] s);
    for (int i = 7; i >= 0; i--) begin
      sb.push_back('{b: s[i], s: (i == 7)});
    end
  endtask

  // Holds reset for two cycles, releases it 2 time units after a falling
  // edge; the next rising edge is the first load edge (cycle 0).
  task automatic apply_reset(input logic act);
    @(negedge clk_8f);
    #2;
    reset          = 1'b1;
    mon_en         = 1'b0;
    sb.delete();
    lane.valid_in  = 1'b0;
    lane.data_in   = 8'h00;
    lane.active_in = act;
    @(negedge clk_8f);
    @(negedge clk_8f);
    #2;
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  // Called right after a falling edge: confirms every expected bit went out.
  task automatic finish_stream(input string name);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d expected bits left, required 0", name, sb.size());
    end
    mon_en = 1'b0;
  endtask

  // Called on a falling edge where a slot should be open; offers one slot.
  task automatic send_slot(input logic v, input logic [7:0] d, input string name);
    lane.valid_in = v;
    lane.data_in  = d;
    n_checks++;
    if (lane.ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready: ready_out=%0b, required 1", name, lane.ready_out);
    end
    push_sym(v ? d : IDL_B);
    repeat (8) @(negedge clk_8f);
  endtask

  // Reset with active_in high; returns at the cycle-31 sample, slot open.
  task automatic go_active();
    apply_reset(1'b1);
    repeat (4) push_sym(COM_B);
    repeat (32) @(negedge clk_8f);
  endtask

  task automatic test_reset();
    lane.valid_in  = 1'b0;
    lane.data_in   = 8'h00;
    lane.active_in = 1'b1;
    @(negedge clk_8f);
    @(negedge clk_8f);
    n_checks += 4;
    if (serial_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_serial: serial_out=%0b, required 0", serial_out);
    end
    if (sym_start !== 1'b0) begin
      n_fail++; $display("FAIL reset_sym_start: sym_start=%0b, required 0", sym_start);
    end
    if (active_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_active: active_out=%0b, required 0", active_out);
    end
    if (lane.ready_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: ready_out=%0b, required 0", lane.ready_out);
    end
  endtask

  task automatic test_sync_idle();
    apply_reset(1'b0);
    repeat (8) push_sym(COM_B);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk_8f);
      n_checks += 2;
      if (lane.ready_out !== 1'b0) begin
        n_fail++; $display("FAIL sync_idle_ready: cycle %0d ready_out=%0b, required 0", k, lane.ready_out);
      end
      if (active_out !== 1'b0) begin
        n_fail++; $display("FAIL sync_idle_active: cycle %0d active_out=%0b, required 0", k, active_out);
      end
    end
    finish_stream("sync_idle");
  endtask

  task automatic test_sync_to_active();
    apply_reset(1'b1);
    repeat (4) push_sym(COM_B);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk_8f);
      n_checks++;
      if (lane.ready_out !== (k == 31)) begin
        n_fail++; $display("FAIL sync_to_active_ready: cycle %0d ready_out=%0b, required %0b",
                           k, lane.ready_out, (k == 31));
      end
      if (k == 23 || k == 24) begin
        n_checks++;
        if (active_out !== (k == 24)) begin
          n_fail++; $display("FAIL sync_to_active_state: cycle %0d active_out=%0b, required %0b",
                             k, active_out, (k == 24));
        end
      end
    end
    send_slot(1'b0, 8'h00, "first_slot_idle");
    finish_stream("sync_to_active");
  endtask

  task automatic test_back_to_back();
    go_active();
    send_slot(1'b1, 8'hA5, "b2b_a5");
    send_slot(1'b1, 8'h3C, "b2b_3c");
    lane.valid_in = 1'b0;
    finish_stream("back_to_back");
  endtask

  task automatic test_idle_gap();
    go_active();
    send_slot(1'b1, 8'h5A, "gap_5a");
    send_slot(1'b0, 8'hEE, "gap_idle");
    send_slot(1'b1, 8'hC3, "gap_c3");
    send_slot(1'b1, 8'hBC, "gap_com_payload");
    lane.valid_in = 1'b0;
    finish_stream("idle_gap");
  endtask

  task automatic test_active_drop();
    go_active();
    lane.valid_in = 1'b1;
    lane.data_in  = 8'h96;
    n_checks++;
    if (lane.ready_out !== 1'b1) begin
      n_fail++; $display("FAIL drop_ready_before: ready_out=%0b, required 1", lane.ready_out);
    end
    push_sym(8'h96);
    @(negedge clk_8f);                 // cycle 32
    lane.valid_in = 1'b0;
    repeat (3) @(negedge clk_8f);      // cycle 35, mid-symbol
    lane.active_in = 1'b0;
    repeat (4) push_sym(COM_B);
    repeat (4) @(negedge clk_8f);      // cycle 39, byte still finishing
    n_checks++;
    if (active_out !== 1'b1) begin
      n_fail++; $display("FAIL drop_active_mid: active_out=%0b, required 1", active_out);
    end
    @(negedge clk_8f);                 // cycle 40, first comma on the line
    lane.active_in = 1'b1;
    n_checks++;
    if (active_out !== 1'b0) begin
      n_fail++; $display("FAIL drop_active_after: active_out=%0b, required 0", active_out);
    end
    for (int k = 41; k <= 71; k++) begin
      @(negedge clk_8f);
      n_checks++;
      if (lane.ready_out !== (k == 71)) begin
        n_fail++; $display("FAIL drop_resync_ready: cycle %0d ready_out=%0b, required %0b",
                           k, lane.ready_out, (k == 71));
      end
    end
    finish_stream("active_drop");
  endtask

  task automatic test_reset_mid_symbol();
    go_active();
    lane.valid_in = 1'b1;
    lane.data_in  = 8'hFF;
    push_sym(8'hFF);
    repeat (5) @(negedge clk_8f);      // cycle 36: bit 3 of 8'hFF on the line
    #2;
    reset  = 1'b1;
    mon_en = 1'b0;
    sb.delete();
    #1;
    n_checks += 3;
    if (serial_out !== 1'b0) begin
      n_fail++; $display("FAIL midreset_serial: serial_out=%0b, required 0", serial_out);
    end
    if (active_out !== 1'b0) begin
      n_fail++; $display("FAIL midreset_active: active_out=%0b, required 0", active_out);
    end
    if (lane.ready_out !== 1'b0) begin
      n_fail++; $display("FAIL midreset_ready: ready_out=%0b, required 0", lane.ready_out);
    end
    lane.valid_in  = 1'b0;
    lane.active_in = 1'b0;
    @(negedge clk_8f);
    @(negedge clk_8f);
    #2;
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (2) push_sym(COM_B);
    repeat (16) @(negedge clk_8f);
    finish_stream("reset_mid_symbol");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sync_idle();
    test_sync_to_active();
    test_back_to_back();
    test_idle_gap();
    test_active_drop();
    test_reset_mid_symbol();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_phy_tx_lane_serializer
